// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM state codes, ALU op codes, instruction classes and the control bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_R     = 4'd7;
    localparam logic [3:0] S_WB_I     = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    typedef enum logic [3:0] {
        R_ALU,
        ORI,
        LUI,
        LW,
        SW,
        BEQ,
        J,
        NOP,
        ILL
    } instr_class_e;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       npc_sel;
        logic       is_jump;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       ext_op;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       mem_to_reg;
    } ctrl_t;

    // States in which an instruction retires and the fetch stage may advance.
    function automatic logic is_commit_state(input logic [3:0] s);
        return (s == S_WB_R)   || (s == S_WB_I)   || (s == S_WB_MEM) ||
               (s == S_MEM_WR) || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mips_ins_decoder.sv
// Combinational instruction classifier: latched IR -> instruction class and
// the ALU operation used by the execute/writeback states.
module mips_ins_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [31:0]  ir_i,
    output instr_class_e cls_o,
    output logic [1:0]   alu_op_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ir_i[31:26];
    assign funct  = ir_i[5:0];

    always_comb begin
        cls_o    = ILL;
        alu_op_o = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                // Only the all-zero word is a nop; any other sll form traps.
                if (ir_i == 32'd0) begin
                    cls_o = NOP;
                end else if (funct == FN_ADDU) begin
                    cls_o = R_ALU;
                end else if (funct == FN_SUBU) begin
                    cls_o    = R_ALU;
                    alu_op_o = ALU_SUB;
                end
            end
            OP_ORI: begin
                cls_o    = ORI;
                alu_op_o = ALU_OR;
            end
            OP_LUI: begin
                cls_o    = LUI;
                alu_op_o = ALU_LUI;
            end
            OP_LW:   cls_o = LW;
            OP_SW:   cls_o = SW;
            OP_BEQ: begin
                cls_o    = BEQ;
                alu_op_o = ALU_SUB;
            end
            OP_J:    cls_o = J;
            default: cls_o = ILL;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS main controller: FSM sequencing, Moore control strobes,
// retired-instruction counter and sticky illegal-instruction trap.
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               alu_zero,
    output logic               ir_write,
    output logic               pc_write,
    output logic               npc_sel,
    output logic               is_jump,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src,
    output logic               ext_op,
    output logic [1:0]         alu_op,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic [3:0]         state_out,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    logic [3:0]         state_q, state_d;
    logic [31:0]        ir_q;
    logic               illegal_q;
    logic [COUNT_W-1:0] count_q;

    instr_class_e dec_cls;
    logic [1:0]   dec_alu_op;
    ctrl_t        ctrl;

    // alu_zero only steers the NPC mux; a branch commits either way.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    mips_ins_decoder u_decoder (
        .ir_i     (ir_q),
        .cls_o    (dec_cls),
        .alu_op_o (dec_alu_op)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (dec_cls)
                    R_ALU, NOP: state_d = S_EXEC_R;
                    ORI, LUI:   state_d = S_EXEC_I;
                    LW, SW:     state_d = S_MEM_ADDR;
                    BEQ:        state_d = S_BRANCH;
                    J:          state_d = S_JUMP;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (dec_cls == LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_WB_MEM;
            S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP:
                        state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_comb begin
        ctrl          = '0;
        ctrl.pc_write = is_commit_state(state_q);
        case (state_q)
            S_FETCH: ctrl.ir_write = 1'b1;
            S_EXEC_R: ctrl.alu_op = dec_alu_op;
            S_WB_R: begin
                ctrl.alu_op    = dec_alu_op;
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = (dec_cls != NOP);
            end
            S_EXEC_I: begin
                ctrl.alu_op  = dec_alu_op;
                ctrl.alu_src = 1'b1;
            end
            S_WB_I: begin
                ctrl.alu_op    = dec_alu_op;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_MEM_ADDR, S_MEM_RD: begin
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.ext_op     = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_op  = ALU_SUB;
                ctrl.npc_sel = 1'b1;
            end
            S_JUMP: ctrl.is_jump = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                ir_q <= instr;
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (ctrl.pc_write) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign ir_write    = ctrl.ir_write;
    assign pc_write    = ctrl.pc_write;
    assign npc_sel     = ctrl.npc_sel;
    assign is_jump     = ctrl.is_jump;
    assign reg_write   = ctrl.reg_write;
    assign reg_dst     = ctrl.reg_dst;
    assign alu_src     = ctrl.alu_src;
    assign ext_op      = ctrl.ext_op;
    assign alu_op      = ctrl.alu_op;
    assign mem_write   = ctrl.mem_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign state_out   = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multi-cycle main controller that sits directly downstream of insfetch and consumes its 32-bit instruction word.
- Latches the instruction and decodes the MIPS subset: addu, subu, ori, lw, sw, beq, lui, j, nop.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Drives the datapath control strobes, including npc_sel, is_jump and a one-cycle PC-advance strobe back to the fetch stage.
- Keeps a retired-instruction counter and a sticky illegal-instruction trap.

Parameters:
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
instr  in  32  instruction word from fetch, valid during S_FETCH
alu_zero  in  1  ALU equality flag, sampled in S_BRANCH
ir_write  out  1  instruction register load strobe
pc_write  out  1  one-cycle commit strobe; fetch stage advances PC
npc_sel  out  1  beq select to NPC
is_jump  out  1  j select to NPC
reg_write  out  1  register-file write enable
reg_dst  out  1  0 = rt, 1 = rd
alu_src  out  1  0 = register, 1 = extended imm16
ext_op  out  1  0 = zero-extend, 1 = sign-extend
alu_op  out  2  00 ADD, 01 SUB, 10 OR, 11 LUI (imm16<<16)
mem_write  out  1  data-memory write enable
mem_to_reg  out  1  writeback source is memory
state_out  out  4  current state encoding, for debug
illegal  out  1  sticky trap flag
instr_count  out  COUNT_W  retired-instruction count

Behaviour:
- All outputs are Moore, decoded from state plus the latched IR. IR is loaded at the end of S_FETCH; instr is ignored in all other states.
- Reset: at a rising edge with rst==0 → state=S_FETCH, IR=0, illegal=0, instr_count=0.
  - Post-reset outputs: ir_write=1; all other strobes 0; alu_op=00.
- Reset mid-instruction abandons the instruction: no pc_write, reg_write or mem_write is issued for it.
- State encoding:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6
  - WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11, TRAP=12
- Transitions:
  - FETCH→DECODE, unconditionally.
  - DECODE by opcode/funct:
    - R-type addu(100001) / subu(100011) / all-zero nop → EXEC_R
    - ori(001101) / lui(001111) → EXEC_I
    - lw(100011) / sw(101011) → MEM_ADDR
    - beq(000100) → BRANCH
    - j(000010) → JUMP
    - anything else, including opcode 0 with another funct or a nonzero sll → TRAP
  - EXEC_R→WB_R; EXEC_I→WB_I; MEM_ADDR→MEM_RD (lw) or MEM_WR (sw); MEM_RD→WB_MEM.
  - WB_R, WB_I, WB_MEM, MEM_WR, BRANCH, JUMP → FETCH.
  - TRAP→TRAP until reset.
- Latency from FETCH to commit:
  - R / ori / lui: 4 cycles; lw: 5; sw: 4; beq: 3; j: 3.
- pc_write:
  - Exactly one cycle per instruction, in its final state (WB_R, WB_I, WB_MEM, MEM_WR, BRANCH, JUMP).
  - In BRANCH it is asserted regardless of alu_zero; NPC chooses PC+4 or the target.
  - Never asserted in TRAP.
- npc_sel=1 only in BRANCH. is_jump=1 only in JUMP. They are mutually exclusive.
- reg_write:
  - 1 in WB_R (except nop), WB_I and WB_MEM.
  - reg_dst=1 in WB_R; reg_dst=0 in WB_I and WB_MEM.
- mem_write=1 only in MEM_WR. mem_to_reg=1 only in WB_MEM.
- ALU controls are held stable across EXEC and WB states:
  - addu: ADD. subu: SUB. ori: OR with ext_op=0. lui: LUI.
  - lw/sw (MEM_ADDR through WB_MEM/MEM_WR): ADD with alu_src=1, ext_op=1.
  - BRANCH: SUB with alu_src=0.
- instr_count increments on every pc_write cycle and wraps modulo 2^COUNT_W.
- illegal is set on entry to TRAP and held until reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants
  - state encoding
  - alu_op codes
  - instruction-class enum (R_ALU, ORI, LUI, LW, SW, BEQ, J, NOP, ILL)
- One natural sub-module, mips_ins_decoder: combinational IR → instruction class and ALU op.
- The FSM, counter and trap remain in mips_mc_controller.

Test Plan:
- Reset with rst=0 for 2 cycles, release → state_out=0, ir_write=1, instr_count=0, illegal=0; next cycle state_out=1.
- addu $3,$1,$2 (0x00221821) → states 0,1,2,7; reg_write=1, reg_dst=1 and pc_write=1 only in cycle 4; instr_count=1.
- lw $4,8($0) (0x8C040008) then sw $4,12($0) (0xAC04000C):
  - lw: 5 cycles, mem_to_reg=1 in WB_MEM.
  - sw: 4 cycles, mem_write=1 exactly once, reg_write never set.
  - instr_count=2.
- beq (0x10220003) with alu_zero=1, then with alu_zero=0 → each 3 cycles; npc_sel=1 and pc_write=1 in BRANCH both times.
- j 0x0C00 (0x08000C00) → is_jump=1 and pc_write=1 in cycle 3; change instr after FETCH → outputs unchanged.
- Illegal opcode 0xFC000000 → TRAP from cycle 3, illegal=1, pc_write stays 0 for 10 cycles; assert rst=0 mid-TRAP → FETCH, illegal=0, count=0.
